// File: rtl/store_align_buffer.sv
// MEM-stage store path: aligns sub-word store data into byte lanes, rejects misaligned stores,
// queues legal stores in a small FIFO drained over valid/ready, and flags load/store address hazards.
module store_align_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_data,
  input  logic [1:0]                   st_width,
  output logic                         st_err,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_byteen,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_hit
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] W_WORD  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_BYTE  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  logic [ADDR_W-1:0] r_addr   [DEPTH];
  logic [DATA_W-1:0] r_data   [DEPTH];
  logic [BE_W-1:0]   r_byteen [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic [OFF_W-1:0]  w_off;
  logic [BE_W-1:0]   w_base;
  logic [DATA_W-1:0] w_dmask;
  logic [BE_W-1:0]   w_byteen;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_st_aligned;
  logic [ADDR_W-1:0] w_ld_aligned;
  logic              w_illegal;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Lane placement and alignment legality of the incoming store
  always_comb begin
    w_off     = st_addr[OFF_W-1:0];
    w_base    = '0;
    w_illegal = 1'b0;
    w_dmask   = '0;
    case (st_width)
      W_BYTE:  w_base = BE_W'(1);
      W_HALF:  begin w_base = BE_W'(3);  w_illegal = st_addr[0];    end
      W_WORD:  begin w_base = BE_W'(15); w_illegal = |st_addr[1:0]; end
      W_DWORD: begin w_base = '1; w_illegal = (DATA_W != 64) || (|st_addr[2:0]); end
      default: w_base = '0;
    endcase
    for (int i = 0; i < int'(BE_W); i++) begin
      w_dmask[8*i +: 8] = {8{w_base[i]}};
    end
    w_byteen     = w_base << w_off;
    w_wdata      = (st_data & w_dmask) << {w_off, 3'b000};
    w_st_aligned = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    w_ld_aligned = {ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = mem_valid && mem_ready;

  assign st_ready  = !w_full;
  assign st_err    = r_err;
  assign count     = r_count;
  assign mem_valid = !w_empty;

  // Head entry is gated so the memory side sees zeros whenever nothing is pending
  assign mem_addr   = w_empty ? '0 : r_addr[r_rd_ptr];
  assign mem_wdata  = w_empty ? '0 : r_data[r_rd_ptr];
  assign mem_byteen = w_empty ? '0 : r_byteen[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset: validity is tracked separately
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr]   <= w_st_aligned;
      r_data[r_wr_ptr]   <= w_wdata;
      r_byteen[r_wr_ptr] <= w_byteen;
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_vld[i] && (r_addr[i] == w_ld_aligned)) ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: one 32-bit and one 64-bit instance, hand-computed expectations.
module tb_store_align_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_st_valid, a_st_ready, a_st_err, a_mem_valid, a_mem_ready, a_ld_hit;
  logic [31:0] a_st_addr, a_st_data, a_mem_addr, a_mem_wdata, a_ld_addr;
  logic [1:0]  a_st_width;
  logic [3:0]  a_mem_byteen;
  logic [2:0]  a_count;

  // 64-bit instance
  logic        b_st_valid, b_st_ready, b_st_err, b_mem_valid, b_mem_ready, b_ld_hit;
  logic [31:0] b_st_addr, b_mem_addr, b_ld_addr;
  logic [63:0] b_st_data, b_mem_wdata;
  logic [1:0]  b_st_width;
  logic [7:0]  b_mem_byteen;
  logic [2:0]  b_count;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] WORD = 2'b00, HALF = 2'b01, BYTE = 2'b10, DWORD = 2'b11;

  store_align_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .reset(reset), .st_valid(a_st_valid), .st_ready(a_st_ready),
    .st_addr(a_st_addr), .st_data(a_st_data), .st_width(a_st_width), .st_err(a_st_err),
    .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_byteen(a_mem_byteen), .count(a_count),
    .ld_addr(a_ld_addr), .ld_hit(a_ld_hit)
  );

  store_align_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .st_valid(b_st_valid), .st_ready(b_st_ready),
    .st_addr(b_st_addr), .st_data(b_st_data), .st_width(b_st_width), .st_err(b_st_err),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_byteen(b_mem_byteen), .count(b_count),
    .ld_addr(b_ld_addr), .ld_hit(b_ld_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
    a_st_addr = addr; a_st_data = data; a_st_width = w; a_st_valid = 1'b1;
    tick();
    a_st_valid = 1'b0;
  endtask

  task automatic b_push(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] w);
    b_st_addr = addr; b_st_data = data; b_st_width = w; b_st_valid = 1'b1;
    tick();
    b_st_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_st_valid = 0; a_st_addr = 0; a_st_data = 0; a_st_width = 0; a_mem_ready = 0; a_ld_addr = 0;
    b_st_valid = 0; b_st_addr = 0; b_st_data = 0; b_st_width = 0; b_mem_ready = 0; b_ld_addr = 0;
    repeat (2) tick();
    n_chk++; if (a_count !== 3'd0) $display("FAIL rst_count got %0d exp 0", a_count); else n_pass++;
    n_chk++; if (a_mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %b exp 0", a_mem_valid); else n_pass++;
    n_chk++; if (a_st_err !== 1'b0) $display("FAIL rst_st_err got %b exp 0", a_st_err); else n_pass++;
    n_chk++; if (a_st_ready !== 1'b1) $display("FAIL rst_st_ready got %b exp 1", a_st_ready); else n_pass++;
    n_chk++; if (b_mem_byteen !== 8'h00) $display("FAIL rst_b_byteen got %h exp 00", b_mem_byteen); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_byte();
    a_st_addr = 32'h13; a_st_data = 32'hAB; a_st_width = BYTE; a_st_valid = 1'b1;
    #1;
    n_chk++; if (a_mem_valid !== 1'b0) $display("FAIL byte_no_bypass got %b exp 0", a_mem_valid); else n_pass++;
    tick();
    a_st_valid = 1'b0;
    n_chk++; if (a_mem_valid !== 1'b1) $display("FAIL byte_valid got %b exp 1", a_mem_valid); else n_pass++;
    n_chk++; if (a_mem_addr !== 32'h10) $display("FAIL byte_addr got %h exp 10", a_mem_addr); else n_pass++;
    n_chk++; if (a_mem_byteen !== 4'b1000) $display("FAIL byte_be got %b exp 1000", a_mem_byteen); else n_pass++;
    n_chk++; if (a_mem_wdata !== 32'hAB000000) $display("FAIL byte_wdata got %h exp ab000000", a_mem_wdata); else n_pass++;
    a_mem_ready = 1'b1; tick(); a_mem_ready = 1'b0;
    n_chk++; if (a_mem_valid !== 1'b0) $display("FAIL byte_drained got %b exp 0", a_mem_valid); else n_pass++;
  endtask

  task automatic test_half_misalign();
    a_push(32'h06, 32'h1234ABCD, HALF);
    n_chk++; if (a_mem_byteen !== 4'b1100) $display("FAIL half_be got %b exp 1100", a_mem_byteen); else n_pass++;
    n_chk++; if (a_mem_wdata !== 32'hABCD0000) $display("FAIL half_wdata got %h exp abcd0000", a_mem_wdata); else n_pass++;
    n_chk++; if (a_mem_addr !== 32'h04) $display("FAIL half_addr got %h exp 4", a_mem_addr); else n_pass++;
    a_push(32'h05, 32'h55, WORD);
    n_chk++; if (a_st_err !== 1'b1) $display("FAIL word_mis_err got %b exp 1", a_st_err); else n_pass++;
    n_chk++; if (a_count !== 3'd1) $display("FAIL word_mis_count got %0d exp 1", a_count); else n_pass++;
    tick();
    n_chk++; if (a_st_err !== 1'b0) $display("FAIL word_mis_pulse got %b exp 0", a_st_err); else n_pass++;
    a_mem_ready = 1'b1; tick(); a_mem_ready = 1'b0;
  endtask

  task automatic test_dword();
    b_push(32'h08, 64'h1122334455667788, DWORD);
    n_chk++; if (b_mem_byteen !== 8'hFF) $display("FAIL dw_be got %h exp ff", b_mem_byteen); else n_pass++;
    n_chk++; if (b_mem_wdata !== 64'h1122334455667788) $display("FAIL dw_wdata got %h", b_mem_wdata); else n_pass++;
    b_push(32'h0C, 64'h1, DWORD);
    n_chk++; if (b_st_err !== 1'b1) $display("FAIL dw_mis_err got %b exp 1", b_st_err); else n_pass++;
    n_chk++; if (b_count !== 3'd1) $display("FAIL dw_mis_count got %0d exp 1", b_count); else n_pass++;
    b_push(32'h13, 64'h00000000000000CD, BYTE);
    n_chk++; if (b_count !== 3'd2) $display("FAIL b_byte_count got %0d exp 2", b_count); else n_pass++;
    a_push(32'h08, 32'h1, DWORD);
    n_chk++; if (a_st_err !== 1'b1) $display("FAIL dw32_err got %b exp 1", a_st_err); else n_pass++;
    n_chk++; if (a_count !== 3'd0) $display("FAIL dw32_count got %0d exp 0", a_count); else n_pass++;
    b_mem_ready = 1'b1; tick();
    n_chk++; if (b_mem_byteen !== 8'b0000_1000) $display("FAIL b_byte_be got %b exp 00001000", b_mem_byteen); else n_pass++;
    n_chk++; if (b_mem_wdata !== 64'h00000000CD000000) $display("FAIL b_byte_wdata got %h", b_mem_wdata); else n_pass++;
    n_chk++; if (b_mem_addr !== 32'h10) $display("FAIL b_byte_addr got %h exp 10", b_mem_addr); else n_pass++;
    tick(); b_mem_ready = 1'b0;
  endtask

  task automatic test_full_drain();
    for (int k = 1; k <= 4; k++) a_push(32'h100 + 32'(4 * (k - 1)), 32'(k), WORD);
    n_chk++; if (a_count !== 3'd4) $display("FAIL full_count got %0d exp 4", a_count); else n_pass++;
    n_chk++; if (a_st_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", a_st_ready); else n_pass++;
    a_push(32'h200, 32'h99, WORD);
    n_chk++; if (a_count !== 3'd4) $display("FAIL full_refuse got %0d exp 4", a_count); else n_pass++;
    n_chk++; if (a_st_err !== 1'b0) $display("FAIL full_no_err got %b exp 0", a_st_err); else n_pass++;
    n_chk++; if (a_mem_wdata !== 32'd1) $display("FAIL stall_hold got %h exp 1", a_mem_wdata); else n_pass++;
    a_mem_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_chk++;
      if (a_mem_valid !== 1'b1 || a_mem_wdata !== 32'(k))
        $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", k, a_mem_valid, a_mem_wdata, 32'(k));
      else n_pass++;
      tick();
    end
    a_mem_ready = 1'b0;
    n_chk++; if (a_count !== 3'd0) $display("FAIL drain_count got %0d exp 0", a_count); else n_pass++;
    a_push(32'h300, 32'd5, WORD);
    a_st_addr = 32'h304; a_st_data = 32'd6; a_st_width = WORD; a_st_valid = 1'b1; a_mem_ready = 1'b1;
    tick();
    a_st_valid = 1'b0; a_mem_ready = 1'b0;
    n_chk++; if (a_count !== 3'd1) $display("FAIL pushpop_count got %0d exp 1", a_count); else n_pass++;
    n_chk++; if (a_mem_wdata !== 32'd6 || a_mem_addr !== 32'h304)
      $display("FAIL pushpop_head got %h@%h exp 6@304", a_mem_wdata, a_mem_addr); else n_pass++;
    a_mem_ready = 1'b1; tick(); a_mem_ready = 1'b0;
  endtask

  task automatic test_ld_hit();
    a_ld_addr = 32'h20; #1;
    n_chk++; if (a_ld_hit !== 1'b0) $display("FAIL ld_empty got %b exp 0", a_ld_hit); else n_pass++;
    a_push(32'h20, 32'h55, WORD);
    a_push(32'h44, 32'h66, WORD);
    a_ld_addr = 32'h22; #1;
    n_chk++; if (a_ld_hit !== 1'b1) $display("FAIL ld_22 got %b exp 1", a_ld_hit); else n_pass++;
    a_ld_addr = 32'h30; #1;
    n_chk++; if (a_ld_hit !== 1'b0) $display("FAIL ld_30 got %b exp 0", a_ld_hit); else n_pass++;
    a_ld_addr = 32'h47; #1;
    n_chk++; if (a_ld_hit !== 1'b1) $display("FAIL ld_47 got %b exp 1", a_ld_hit); else n_pass++;
    a_mem_ready = 1'b1; tick(); a_mem_ready = 1'b0;
    a_ld_addr = 32'h20; #1;
    n_chk++; if (a_ld_hit !== 1'b0) $display("FAIL ld_popped got %b exp 0", a_ld_hit); else n_pass++;
    a_mem_ready = 1'b1; tick(); a_mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < 3; k++) a_push(32'h200 + 32'(4 * k), 32'hA0 + 32'(k), WORD);
    n_chk++; if (a_count !== 3'd3 || a_mem_valid !== 1'b1)
      $display("FAIL pre_rst got c=%0d v=%b exp c=3 v=1", a_count, a_mem_valid); else n_pass++;
    reset = 1'b1;
    a_st_addr = 32'h05; a_st_width = WORD; a_st_valid = 1'b1;
    tick();
    a_st_valid = 1'b0; reset = 1'b0;
    n_chk++; if (a_count !== 3'd0) $display("FAIL mid_rst_count got %0d exp 0", a_count); else n_pass++;
    n_chk++; if (a_mem_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", a_mem_valid); else n_pass++;
    n_chk++; if (a_st_err !== 1'b0) $display("FAIL mid_rst_err got %b exp 0", a_st_err); else n_pass++;
    n_chk++; if (a_mem_byteen !== 4'b0 || a_mem_wdata !== 32'b0 || a_mem_addr !== 32'b0)
      $display("FAIL mid_rst_head got be=%b d=%h a=%h exp zeros", a_mem_byteen, a_mem_wdata, a_mem_addr); else n_pass++;
    tick();
    n_chk++; if (a_mem_valid !== 1'b0) $display("FAIL post_rst_valid got %b exp 0", a_mem_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_misalign();
    test_dword();
    test_full_drain();
    test_ld_hit();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
